rx_scan_sequencer: RTL and testbench

Timing/command controller for the 8-channel ultrasound receive path. Per frame it steps through scan lines and focus zones. For each shot it issues the transmit pulse gate, the receive-window gate, the per-sample strobe and the line/focus indices consumed by the Data_A..Data_H capture logic. It signals frame completion with End_Gate. It sits beside the receive data generator/front end and is the sole source of Pr_Gate, RX_Gate, Sample_Gate, End_Gate, Line_Num and Focus_Num.

---
 rtl/rx_scan_sequencer.sv | 158 +++++++++++++++
 tb/tb_rx_scan_sequencer.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/rx_scan_sequencer.sv
// Ultrasound receive scan sequencer: per-shot PR/WAIT/RX/GAP gating over lines and focus zones.
// Optional RX_SEQ_CONT_EN: restart frames back-to-back after END until Stop.
module rx_scan_sequencer #(
  parameter int NUM_LINES  = 128,
  parameter int PR_LEN     = 50,
  parameter int RX_DELAY   = 100,
  parameter int RX_LEN     = 4096,
  parameter int SAMPLE_DIV = 2,
  parameter int LINE_GAP   = 20
) (
  input  logic       clk_50M,
  input  logic       reset_n,
  input  logic       Start,
  input  logic       Stop,
  input  logic [1:0] Focus_Cnt,
  output logic [7:0] Line_Num,
  output logic [1:0] Focus_Num,
  output logic       Pr_Gate,
  output logic       RX_Gate,
  output logic       Sample_Gate,
  output logic       End_Gate,
  output logic       Busy
);

  typedef enum logic [2:0] {
    IDLE, PR, WAIT, RX, GAP, END
  } state_t;

  localparam logic [15:0] PR_LD = 16'(PR_LEN - 1);
  localparam logic [15:0] WT_LD = 16'(RX_DELAY - 1);
  localparam logic [15:0] RX_LD = 16'(RX_LEN - 1);
  localparam logic [15:0] SD_LD = 16'(SAMPLE_DIV - 1);
  localparam logic [15:0] GP_LD = 16'(LINE_GAP - 1);
  localparam logic [7:0]  LAST  = 8'(NUM_LINES - 1);

  state_t      state, state_n;
  logic [15:0] cnt, cnt_n;
  logic [15:0] scnt, scnt_n;
  logic [7:0]  line_n;
  logic [1:0]  focus_n;
  logic [1:0]  fcnt, fcnt_n;
  logic        stop_q, stop_n;
  logic        samp_n;

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    scnt_n  = scnt;
    line_n  = Line_Num;
    focus_n = Focus_Num;
    fcnt_n  = fcnt;
    samp_n  = 1'b0;
    stop_n  = stop_q | (Stop & (state != IDLE));
    unique case (state)
      IDLE: begin
        if (Start && !Stop) begin
          state_n = PR;
          cnt_n   = PR_LD;
          line_n  = 8'd0;
          focus_n = 2'd0;
          fcnt_n  = Focus_Cnt;
        end
      end
      PR: begin
        if (cnt == 16'd0) begin
          state_n = WAIT;
          cnt_n   = WT_LD;
        end else begin
          cnt_n = cnt - 16'd1;
        end
      end
      WAIT: begin
        if (cnt == 16'd0) begin
          state_n = RX;
          cnt_n   = RX_LD;
          scnt_n  = 16'd0;
          samp_n  = 1'b1;
        end else begin
          cnt_n = cnt - 16'd1;
        end
      end
      RX: begin
        if (cnt == 16'd0) begin
          state_n = GAP;
          cnt_n   = GP_LD;
        end else begin
          cnt_n  = cnt - 16'd1;
          scnt_n = (scnt == 16'd0) ? SD_LD
                                   : scnt - 16'd1;
          samp_n = (scnt_n == 16'd0);
        end
      end
      GAP: begin
        if (cnt != 16'd0) begin
          cnt_n = cnt - 16'd1;
        end else if (stop_q || Stop) begin
          state_n = IDLE;
        end else if (Focus_Num < fcnt) begin
          state_n = PR;
          cnt_n   = PR_LD;
          focus_n = Focus_Num + 2'd1;
        end else if (Line_Num < LAST) begin
          state_n = PR;
          cnt_n   = PR_LD;
          focus_n = 2'd0;
          line_n  = Line_Num + 8'd1;
        end else begin
          state_n = END;
        end
      end
      END: begin
`ifdef RX_SEQ_CONT_EN
        state_n = PR;
        cnt_n   = PR_LD;
        line_n  = 8'd0;
        focus_n = 2'd0;
        fcnt_n  = Focus_Cnt;
`else
        state_n = IDLE;
`endif
      end
      default: state_n = IDLE;
    endcase
    if (state_n == IDLE) stop_n = 1'b0;
  end

  // Gates are registered from next state so they align with the state register.
  always_ff @(posedge clk_50M or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      cnt         <= 16'd0;
      scnt        <= 16'd0;
      fcnt        <= 2'd0;
      stop_q      <= 1'b0;
      Line_Num    <= 8'd0;
      Focus_Num   <= 2'd0;
      Pr_Gate     <= 1'b0;
      RX_Gate     <= 1'b0;
      Sample_Gate <= 1'b0;
      End_Gate    <= 1'b0;
      Busy        <= 1'b0;
    end else begin
      state       <= state_n;
      cnt         <= cnt_n;
      scnt        <= scnt_n;
      fcnt        <= fcnt_n;
      stop_q      <= stop_n;
      Line_Num    <= line_n;
      Focus_Num   <= focus_n;
      Pr_Gate     <= (state_n == PR);
      RX_Gate     <= (state_n == RX);
      Sample_Gate <= samp_n;
      End_Gate    <= (state_n == END);
      Busy        <= (state_n != IDLE);
    end
  end

endmodule

// File: tb/tb_rx_scan_sequencer.sv
// Scoreboard bench for rx_scan_sequencer: shot/end expectations queued, monitor checks.
// Build with RX_SEQ_CONT_EN defined to exercise continuous frames.
module tb_rx_scan_sequencer;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       Start = 1'b0;
  logic       Stop = 1'b0;
  logic [1:0] Focus_Cnt = 2'd0;
  logic [7:0] Line_Num;
  logic [1:0] Focus_Num;
  logic       Pr_Gate, RX_Gate, Sample_Gate;
  logic       End_Gate, Busy;

  always #5 clk = ~clk;

  rx_scan_sequencer #(
    .NUM_LINES(3), .PR_LEN(4), .RX_DELAY(3),
    .RX_LEN(8), .SAMPLE_DIV(2), .LINE_GAP(2)
  ) dut (
    .clk_50M(clk), .reset_n(reset_n),
    .Start(Start), .Stop(Stop),
    .Focus_Cnt(Focus_Cnt),
    .Line_Num(Line_Num), .Focus_Num(Focus_Num),
    .Pr_Gate(Pr_Gate), .RX_Gate(RX_Gate),
    .Sample_Gate(Sample_Gate),
    .End_Gate(End_Gate), .Busy(Busy)
  );

  typedef struct {
    int line;
    int focus;
  } shot_t;

  shot_t shot_q[$];
  int    end_q[$];
  int    checks = 0;
  int    errors = 0;
  bit    track = 1'b1;

  task automatic chk(string n, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d want %0d @%0t",
               n, act, exp, $time);
    end
  endtask

  task automatic push_frame(int lines, int fz);
    shot_t s;
    for (int l = 0; l < lines; l++)
      for (int f = 0; f <= fz; f++) begin
        s.line = l;
        s.focus = f;
        shot_q.push_back(s);
      end
  endtask

  // Monitor
  int   cyc = 0;
  int   frame_start = 0;
  bit   pr_prev = 0, rx_prev = 0, busy_prev = 0;
  bit   in_shot = 0, end_prev = 0;
  int   pr_cnt, wt_cnt, rx_cnt;
  int   sh_line, sh_focus;
  logic [7:0] smask;
  shot_t e;

  always @(negedge clk) begin
    cyc++;
    if (!track || !reset_n) begin
      in_shot  = 0;
      end_prev = 0;
    end else begin
      if (end_prev) begin
`ifdef RX_SEQ_CONT_EN
        chk("busy_after_end", Busy, 1);
`else
        chk("busy_after_end", Busy, 0);
`endif
        end_prev = 0;
      end
      if (Pr_Gate && !pr_prev) begin
        if (shot_q.size() == 0) begin
          chk("unexpected_pr_line", Line_Num, -1);
        end else begin
          e = shot_q.pop_front();
          chk("shot_line", Line_Num, e.line);
          chk("shot_focus", Focus_Num, e.focus);
        end
        if (!busy_prev) frame_start = cyc;
        in_shot  = 1;
        pr_cnt   = 0;
        wt_cnt   = 0;
        rx_cnt   = 0;
        smask    = 8'h00;
        sh_line  = Line_Num;
        sh_focus = Focus_Num;
      end
      if (in_shot) begin
        if (Pr_Gate) pr_cnt++;
        else if (RX_Gate) begin
          if (Sample_Gate && rx_cnt < 8) smask[rx_cnt] = 1'b1;
          rx_cnt++;
        end else if (rx_cnt == 0) wt_cnt++;
      end
      if (in_shot && rx_prev && !RX_Gate) begin
        chk("pr_len", pr_cnt, 4);
        chk("rx_delay", wt_cnt, 3);
        chk("rx_len", rx_cnt, 8);
        chk("sample_mask", smask, 8'h55);
        chk("line_stable", Line_Num, sh_line);
        chk("focus_stable", Focus_Num, sh_focus);
        in_shot = 0;
      end
      if (Sample_Gate) chk("sample_in_rx", RX_Gate, 1);
      if (End_Gate) begin
        if (end_q.size() == 0)
          chk("unexpected_end", cyc - frame_start, -1);
        else
          chk("end_offset", cyc - frame_start, end_q.pop_front());
        frame_start = cyc + 1;
        end_prev = 1;
      end
    end
    pr_prev   = Pr_Gate;
    rx_prev   = RX_Gate;
    busy_prev = Busy;
  end

  task automatic start_frame(logic [1:0] fz);
    @(negedge clk);
    Start = 1'b1;
    Focus_Cnt = fz;
    @(negedge clk);
    Start = 1'b0;
  endtask

  task automatic pulse_stop();
    @(negedge clk);
    Stop = 1'b1;
    @(negedge clk);
    Stop = 1'b0;
  endtask

  task automatic wait_idle(int budget);
    int n = 0;
    @(negedge clk);
    while (Busy && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk("idle_timeout", Busy, 0);
  endtask

  task automatic wait_rx_line(int ln);
    int n = 0;
    while (!(RX_Gate && Line_Num == 8'(ln)) && n < 500) begin
      @(negedge clk);
      n++;
    end
    chk("rx_line_timeout", (n < 500) ? 1 : 0, 1);
  endtask

  task automatic wait_end();
    int n = 0;
    @(negedge clk);
    while (!End_Gate && n < 500) begin
      @(negedge clk);
      n++;
    end
    chk("end_timeout", (n < 500) ? 1 : 0, 1);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_line", Line_Num, 0);
    chk("rst_focus", Focus_Num, 0);
    chk("rst_pr", Pr_Gate, 0);
    chk("rst_rx", RX_Gate, 0);
    chk("rst_sample", Sample_Gate, 0);
    chk("rst_end", End_Gate, 0);
    chk("rst_busy", Busy, 0);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);

`ifdef RX_SEQ_CONT_EN
    push_frame(3, 0);
    end_q.push_back(51);
    push_frame(3, 0);
    end_q.push_back(51);
    push_frame(2, 0);
    start_frame(2'd0);
    wait_end();
    wait_end();
    repeat (20) @(negedge clk);
    pulse_stop();
    wait_idle(300);
    chk("cont_stop_line", Line_Num, 1);
`else
    // Frame with a single focus zone
    push_frame(3, 0);
    end_q.push_back(51);
    start_frame(2'd0);
    wait_idle(300);
    chk("final_line", Line_Num, 2);
    chk("final_focus", Focus_Num, 0);

    // Two focus zones, stray Start mid-frame
    push_frame(3, 1);
    end_q.push_back(102);
    start_frame(2'd1);
    repeat (30) @(negedge clk);
    start_frame(2'd0);
    wait_idle(300);
    chk("final_line_f1", Line_Num, 2);
    chk("final_focus_f1", Focus_Num, 1);

    // Stop during shot (1,0) RX
    push_frame(2, 0);
    start_frame(2'd0);
    wait_rx_line(1);
    pulse_stop();
    wait_idle(300);
    chk("stop_line", Line_Num, 1);
    repeat (20) @(negedge clk);
    chk("stop_no_busy", Busy, 0);

    // Start with Stop in the same cycle
    @(negedge clk);
    Start = 1'b1;
    Stop  = 1'b1;
    @(negedge clk);
    Start = 1'b0;
    Stop  = 1'b0;
    repeat (5) @(negedge clk);
    chk("ss_busy", Busy, 0);
    chk("ss_pr", Pr_Gate, 0);

    // Asynchronous reset mid-RX
    track = 1'b0;
    start_frame(2'd0);
    wait_rx_line(1);
    #2 reset_n = 1'b0;
    #1;
    chk("arst_rx", RX_Gate, 0);
    chk("arst_sample", Sample_Gate, 0);
    chk("arst_pr", Pr_Gate, 0);
    chk("arst_busy", Busy, 0);
    chk("arst_line", Line_Num, 0);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    track = 1'b1;
    push_frame(3, 0);
    end_q.push_back(51);
    start_frame(2'd0);
    wait_idle(300);
    chk("post_rst_line", Line_Num, 2);
`endif

    repeat (5) @(negedge clk);
    chk("shot_q_empty", shot_q.size(), 0);
    chk("end_q_empty", end_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got 1 want 0");
    $fatal(1, "timeout");
  end

endmodule
